// File: rtl/native_dma_master_if.sv
// rtl/native_dma_master_if.sv - PicoRV32 native memory bus bundle
// Purpose: groups the native memory handshake signals shared by an initiator
//          and a responder.
// Ports (signals):
//   mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb : initiator -> responder
//   mem_ready, mem_rdata                                 : responder -> initiator
interface native_dma_master_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/native_dma_master.sv
// rtl/native_dma_master.sv - word-copy DMA initiator on the PicoRV32 native bus
// Purpose: copies len_words 32-bit words from src_addr to dst_addr using
//          alternating single-word reads and writes, one idle cycle between
//          transactions, with a per-transaction ready timeout.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   start              : one-cycle request, sampled only when idle
//   src_addr, dst_addr : word-aligned byte addresses
//   len_words          : number of words to copy
//   busy, done, error  : status (done is a one-cycle pulse, error is sticky)
//   words_done         : words fully written in the current/last transfer
//   mem                : native memory bus, initiator side
module native_dma_master #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  native_dma_master_if.master mem
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, wd_q, wd_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             hs;

  assign hs = valid_q && mem.mem_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words == '0) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = len_words;
            wd_d    = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            tmo_d   = '0;
            valid_d = 1'b1;
            addr_d  = src_addr;
            wstrb_d = 4'b0000;
            state_d = RD;
          end
        end
      end

      RD, WR: begin
        if (hs) begin
          valid_d = 1'b0;
          tmo_d   = '0;
          if (state_q == RD) begin
            wdata_d = mem.mem_rdata;
            src_d   = src_q + 32'd4;
            state_d = RD_GAP;
          end else begin
            dst_d   = dst_q + 32'd4;
            wd_d    = wd_q + ONE;
            wstrb_d = 4'b0000;
            if (wd_q + ONE == len_q) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WR_GAP;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // Responder never answered: abandon the transfer, keep progress count.
          valid_d = 1'b0;
          tmo_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          wstrb_d = 4'b0000;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RD_GAP: begin
        valid_d = 1'b1;
        addr_d  = dst_q;
        wstrb_d = 4'b1111;
        state_d = WR;
      end

      WR_GAP: begin
        valid_d = 1'b1;
        addr_d  = src_q;
        wstrb_d = 4'b0000;
        state_d = RD;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_done    = wd_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_instr = 1'b0;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_native_dma_master.sv
// tb/tb_native_dma_master.sv - self-checking bench for native_dma_master
module tb_native_dma_master;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, error;
  logic [15:0] words_done;

  native_dma_master_if bus();

  native_dma_master #(.LEN_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem(bus)
  );

  always #5 clk = ~clk;

  // 1KB RAM responder: ready one cycle after valid, unmapped addresses never answer.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!resetn) bus.mem_ready <= 1'b0;
    else bus.mem_ready <= bus.mem_valid && !bus.mem_ready && (bus.mem_addr < 32'h400);
    if (bus.mem_valid && bus.mem_ready && bus.mem_wstrb == 4'hF)
      ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = ram[bus.mem_addr[9:2]];

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [3:0] strb; logic [31:0] data;} txn_t;
  txn_t exp_q[$];

  // Scoreboard: compare every handshake against the next expected transaction.
  always @(negedge clk) begin
    if (resetn && bus.mem_valid && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_txn", bus.mem_addr, 32'hFFFF_FFFF);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        check("txn_addr", bus.mem_addr, t.addr);
        check("txn_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, t.strb});
        if (t.strb == 4'hF) check("txn_wdata", bus.mem_wdata, t.data);
      end
    end
  end

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: s + 32'(4*i), strb: 4'h0, data: 32'h0});
      exp_q.push_back('{addr: d + 32'(4*i), strb: 4'hF, data: ram[8'((s >> 2) + 32'(i))]});
    end
  endtask

  // Drives one start and observes cycles 1..budget after the start edge.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int restart, input int budget,
                     output int dcyc, output int ndone, output int nval, output int nbusy);
    dcyc = -1; ndone = 0; nval = 0; nbusy = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = (k == restart);
      if (k == restart) len_words = 16'd0;
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = k;
      end
      if (bus.mem_valid) nval++;
      if (busy) nbusy++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] src; logic [31:0] dst; logic [15:0] len;
    logic exp_err; int exp_cyc; logic [15:0] exp_words;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int dc, nd, nv, nb, n;
    vecs[0] = '{32'h040, 32'h080, 16'd0, 1'b0, 1,  16'd0};
    vecs[1] = '{32'h042, 32'h080, 16'd2, 1'b1, 1,  16'd0};
    vecs[2] = '{32'h040, 32'h081, 16'd2, 1'b1, 1,  16'd0};
    vecs[3] = '{32'h040, 32'h080, 16'd3, 1'b0, 18, 16'd3};
    vecs[4] = '{32'h100, 32'h200, 16'd1, 1'b0, 6,  16'd1};
    vecs[5] = '{32'h3F0, 32'h300, 16'd4, 1'b0, 24, 16'd4};
    vecs[6] = '{32'h040, 32'h080, 16'd0, 1'b0, 1,  16'd4};

    for (int i = 0; i < 256; i++) ram[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
    ram[16] = 32'hA1; ram[17] = 32'hB2; ram[18] = 32'hC3;

    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst_status", {29'd0, busy, done, error}, 32'd0);
    check("rst_words", {16'd0, words_done}, 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      n = int'(vecs[i].len);
      if (vecs[i].exp_cyc > 1) push_copy(vecs[i].src, vecs[i].dst, n);
      run(vecs[i].src, vecs[i].dst, vecs[i].len, 0, 6*n + 8, dc, nd, nv, nb);
      check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_cyc);
      check($sformatf("v%0d_done_count", i), nd, 1);
      check($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_words", i), {16'd0, words_done}, {16'd0, vecs[i].exp_words});
      check($sformatf("v%0d_valid_cycles", i), nv, (vecs[i].exp_cyc > 1) ? 4*n : 0);
      check($sformatf("v%0d_busy_cycles", i), nb, (vecs[i].exp_cyc > 1) ? 6*n - 1 : 0);
      check($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
      if (vecs[i].exp_cyc > 1)
        for (int w = 0; w < n; w++)
          check($sformatf("v%0d_ram%0d", i, w), ram[8'((vecs[i].dst >> 2) + 32'(w))],
                ram[8'((vecs[i].src >> 2) + 32'(w))]);
    end
    check("plan_w32", ram[32], 32'hA1);
    check("plan_w33", ram[33], 32'hB2);
    check("plan_w34", ram[34], 32'hC3);

    // Timeout: read answers, write to unmapped space never does.
    exp_q.push_back('{addr: 32'h40, strb: 4'h0, data: 32'h0});
    run(32'h040, 32'h800, 16'd1, 0, 30, dc, nd, nv, nb);
    check("tmo_done_cycle", dc, 20);
    check("tmo_done_count", nd, 1);
    check("tmo_valid_cycles", nv, 18);
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_words", {16'd0, words_done}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_sb_empty", exp_q.size(), 0);

    // Reset while the first write is pending (cycle 4).
    push_copy(32'h040, 32'h380, 2);
    @(negedge clk);
    src_addr = 32'h040; dst_addr = 32'h380; len_words = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_wr_pending", {31'd0, bus.mem_valid && bus.mem_wstrb == 4'hF}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rst_mid_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_sb_left", exp_q.size(), 3);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_copy(32'h040, 32'h380, 2);
    run(32'h040, 32'h380, 16'd2, 0, 20, dc, nd, nv, nb);
    check("post_rst_done_cycle", dc, 12);
    check("post_rst_sb_empty", exp_q.size(), 0);
    check("post_rst_ram0", ram[224], 32'hA1);
    check("post_rst_ram1", ram[225], 32'hB2);

    // A second start during a transfer is ignored.
    push_copy(32'h100, 32'h140, 2);
    run(32'h100, 32'h140, 16'd2, 3, 20, dc, nd, nv, nb);
    check("restart_done_cycle", dc, 12);
    check("restart_done_count", nd, 1);
    check("restart_words", {16'd0, words_done}, 32'd2);
    check("restart_sb_empty", exp_q.size(), 0);
    check("restart_ram0", ram[80], ram[64]);
    check("restart_ram1", ram[81], ram[65]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/native_dma_master.md
Name: native_dma_master

Overview:
- Bus initiator for the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Copies a block of 32-bit words from a source address to a destination address using alternating single-word reads and writes.
- Sits beside the CPU as a second master, or alone in a bench against the simple 1KB RAM responder; it is the initiator end of the same protocol that responder serves.

Parameters:
- LEN_W, 16, width of the word-count input and progress counter.
- TIMEOUT, 256, cycles mem_valid may stay high without mem_ready before the transfer aborts (≥2).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  source byte address; must be word-aligned.
- dst_addr  in  32  destination byte address; must be word-aligned.
- len_words  in  LEN_W  number of words to copy.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse (success or error).
- error  out  1  status of the last transfer; sticky until the next accepted start.
- words_done  out  LEN_W  words fully written in the current/last transfer.
- mem_valid  out  1  request valid.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder accept.
- mem_addr  out  32  request address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b0000 for read, 4'b1111 for write.
- mem_rdata  in  32  read data, valid when mem_valid && mem_ready.

Behaviour:
- All outputs are registered. On reset (resetn low at a posedge), at the next edge: mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, words_done = 0; state = IDLE.
- Reset mid-transfer aborts immediately, with no done pulse.
- States: IDLE, RD, RD_GAP, WR, WR_GAP.
- IDLE, start=1, len_words=0: done=1 and error=0 next cycle; no bus traffic.
- IDLE, start=1, src_addr[1:0]≠0 or dst_addr[1:0]≠0: done=1 and error=1 next cycle; no bus traffic.
- IDLE, otherwise: latch addresses and length; clear error and words_done; busy=1; go to RD.
  - mem_valid=1 with mem_addr=src and wstrb=0 from the next cycle.
- Request rule: while mem_valid=1, addr/wdata/wstrb are held stable. A transaction completes at a posedge with mem_valid && mem_ready. mem_valid is 0 in the following cycle (exactly one idle cycle between transactions).
- RD completion: latch mem_rdata into mem_wdata; src += 4; go to RD_GAP.
- RD_GAP: one cycle, then WR with mem_addr=dst and wstrb=4'b1111.
- WR completion: dst += 4; words_done += 1.
  - If words_done reaches len_words: busy=0, done=1 in the next cycle, go to IDLE.
  - Otherwise go to WR_GAP, then RD.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0.
- Timeout: a counter runs while mem_valid=1 and resets at each handshake. When it reaches TIMEOUT with no ready:
  - mem_valid=0, error=1, done=1, busy=0, state IDLE.
  - words_done keeps its count.
- start while busy is ignored.
- mem_ready while mem_valid=0 is ignored.
- done is high for exactly one cycle per accepted start.
- Timing against a responder with ready one cycle after valid: 6 cycles per word. For N words the last write completes at the end of cycle 6N−1 (cycle 1 = first cycle after the start edge), and done is high in cycle 6N.

Test Plan:
- src=0x40, dst=0x80, len=3, RAM words 16..18 = 0xA1,0xB2,0xC3 → words 32..34 = 0xA1,0xB2,0xC3; 3 reads (wstrb 0000) and 3 writes (wstrb 1111), one idle cycle after each; done in cycle 18 only; words_done=3; error=0.
- len=0 → done=1 in cycle 1, error=0, mem_valid never asserted.
- src=0x42, dst=0x80, len=2 → done=1 and error=1 in cycle 1; no mem_valid.
- TIMEOUT=16, src=0x40, dst=0x800 (unmapped, never ready), len=1 → read completes; write holds mem_valid for 16 cycles, then mem_valid=0, error=1, done pulse, words_done=0.
- resetn low for 1 cycle while WR is pending → next cycle mem_valid=0, busy=0, done=0; a new start afterwards copies correctly.
- start pulsed again in cycle 3 of a len=2 transfer → ignored; exactly 2 words copied; a single done pulse.
